freq_div_ctrl: RTL and testbench

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

---
 rtl/freq_div_pkg.sv | 13 +
 rtl/freq_div_phase_cnt.sv | 21 ++
 rtl/freq_div_ctrl.sv | 127 ++++++++++++
 tb/tb_freq_div_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and
// the minimum phase length that a zero request is clamped up to.
package freq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned LEN_MIN = 1;

endpackage

// File: rtl/freq_div_phase_cnt.sv
// Phase counter: counts up from 0, flags the last cycle of a phase of
// length `limit` (limit is always >= 1 by construction in the caller).
module freq_div_phase_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk_in) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + WIDTH'(1);
  end

  assign tc = (cnt == limit - WIDTH'(1));

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock divider with separate high/low phase lengths and a
// valid/ready config port whose updates take effect only between periods.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | stopped, clk_out low, counter held at 0
//   HIGH    | high phase, lasts act_high cycles
//   LOW     | low phase, lasts act_low cycles; its last cycle is the boundary
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEF_HIGH = 2,
  parameter int DEF_LOW  = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [WIDTH-1:0] cfg_low,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             period_tick
);

  localparam logic [WIDTH-1:0] LEN_ONE = WIDTH'(LEN_MIN);

  function automatic logic [WIDTH-1:0] clamp_len(input logic [WIDTH-1:0] v);
    return (v == '0) ? LEN_ONE : v;
  endfunction

  localparam logic [WIDTH-1:0] DEF_HIGH_C = clamp_len(WIDTH'(DEF_HIGH));
  localparam logic [WIDTH-1:0] DEF_LOW_C  = clamp_len(WIDTH'(DEF_LOW));

  state_t           state;
  logic [WIDTH-1:0] act_high, act_low;
  logic [WIDTH-1:0] pend_high, pend_low;
  logic             pend_vld;
  logic [WIDTH-1:0] cnt, limit;
  logic             tc, cnt_clr, accept;

  assign limit     = (state == ST_LOW) ? act_low : act_high;
  assign cnt_clr   = (state == ST_IDLE) || tc;
  assign cfg_ready = ~pend_vld;
  assign accept    = cfg_valid && ~pend_vld;

  freq_div_phase_cnt #(.WIDTH(WIDTH)) u_phase_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (cnt_clr),
    .limit  (limit),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= ST_IDLE;
      act_high    <= DEF_HIGH_C;
      act_low     <= DEF_LOW_C;
      pend_high   <= '0;
      pend_low    <= '0;
      pend_vld    <= 1'b0;
      clk_out     <= 1'b0;
      rise_tick   <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      rise_tick   <= 1'b0;
      period_tick <= 1'b0;

      // While stopped a config goes live at once; while running it waits.
      if (accept) begin
        if (state == ST_IDLE) begin
          act_high <= clamp_len(cfg_high);
          act_low  <= clamp_len(cfg_low);
        end else begin
          pend_high <= clamp_len(cfg_high);
          pend_low  <= clamp_len(cfg_low);
          pend_vld  <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_HIGH;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (tc) begin
            state       <= ST_LOW;
            clk_out     <= 1'b0;
            period_tick <= (act_low == LEN_ONE);
          end
        end
        ST_LOW: begin
          if (tc) begin
            if (pend_vld) begin
              act_high <= pend_high;
              act_low  <= pend_low;
              pend_vld <= 1'b0;
            end
            if (enable) begin
              state     <= ST_HIGH;
              clk_out   <= 1'b1;
              rise_tick <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            // Registered tick: raise it for the cycle that will be the last of LOW.
            period_tick <= (cnt + WIDTH'(1) == act_low - WIDTH'(1));
          end
        end
        default: begin
          state   <= ST_IDLE;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: a vector table for steady-state and
// config-handshake behaviour, plus short sequences for stop/clamp/reset cases.
module tb_freq_div_ctrl;

  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_high = '0;
  logic [WIDTH-1:0] cfg_low = '0;
  logic             clk_out, rise_tick, period_tick;

  int n_cmp = 0;
  int n_bad = 0;

  freq_div_ctrl #(.WIDTH(WIDTH), .DEF_HIGH(2), .DEF_LOW(2)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .period_tick (period_tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       e_clk;
    logic       e_rise;
    logic       e_per;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic v, input int hi, input int lo,
                     input logic c, input logic rs, input logic p, input logic rd);
    vec_t t;
    t.rst = r; t.en = en; t.vld = v; t.hi = 8'(hi); t.lo = 8'(lo);
    t.e_clk = c; t.e_rise = rs; t.e_per = p; t.e_rdy = rd;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic v, input int hi, input int lo);
    rst = r; enable = en; cfg_valid = v;
    cfg_high = WIDTH'(hi); cfg_low = WIDTH'(lo);
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all(input string tag, input logic c, input logic rs, input logic p, input logic rd);
    check({tag, " clk_out"}, clk_out, c);
    check({tag, " rise_tick"}, rise_tick, rs);
    check({tag, " period_tick"}, period_tick, p);
    check({tag, " cfg_ready"}, cfg_ready, rd);
  endtask

  logic [11:0] exp_clk, exp_per;
  logic [7:0]  exp8_clk, exp8_per, exp8_rise;

  initial begin
    //   rst en vld hi lo | clk rise per rdy
    add(1, 0, 0, 0, 0,   0, 0, 0, 1);  // reset
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);  // default 2/2 run
    add(0, 1, 0, 0, 0,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1);
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);
    add(0, 1, 0, 0, 0,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1);
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);
    add(0, 1, 1, 3, 5,   1, 0, 0, 0);  // mid-HIGH accept 3/5 -> pending
    add(0, 1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 0);
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);  // 3/5 applied
    add(0, 1, 0, 0, 0,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1);
    add(0, 1, 1, 1, 1,   1, 1, 0, 0);  // accept 1/1 on the boundary edge
    add(0, 1, 0, 0, 0,   1, 0, 0, 0);  // still 3/5
    add(0, 1, 0, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 0);
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);  // 1/1 applied
    add(0, 1, 0, 0, 0,   0, 0, 1, 1);
    add(0, 1, 0, 0, 0,   1, 1, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].vld, int'(vecs[i].hi), int'(vecs[i].lo));
      check_all($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_rise, vecs[i].e_per, vecs[i].e_rdy);
    end

    // Stop request in the first HIGH cycle of a 4/4 period.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4, 4);
    check("stop cfg_ready idle", cfg_ready, 1'b1);
    check("stop clk_out idle", clk_out, 1'b0);
    step(0, 1, 0, 0, 0);
    check("stop first high", clk_out, 1'b1);
    exp_clk = 12'b0000_0000_0111;
    exp_per = 12'b0000_0100_0000;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("stop k%0d clk_out", k), clk_out, exp_clk[k]);
      check($sformatf("stop k%0d period_tick", k), period_tick, exp_per[k]);
      check($sformatf("stop k%0d rise_tick", k), rise_tick, 1'b0);
    end

    // Zero lengths clamp to 1/1.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    exp8_clk  = 8'b0101_0101;
    exp8_rise = 8'b0101_0101;
    exp8_per  = 8'b1010_1010;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 0);
      check($sformatf("clamp k%0d clk_out", k), clk_out, exp8_clk[k]);
      check($sformatf("clamp k%0d rise_tick", k), rise_tick, exp8_rise[k]);
      check($sformatf("clamp k%0d period_tick", k), period_tick, exp8_per[k]);
    end

    // Reset in LOW with a config pending.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 6, 6);
    check("rst pending ready", cfg_ready, 1'b0);
    step(0, 1, 0, 0, 0);
    check("rst in LOW clk_out", clk_out, 1'b0);
    step(1, 1, 0, 0, 0);
    check_all("rst applied", 1'b0, 1'b0, 1'b0, 1'b1);
    exp8_clk = 8'b0011_0011;
    exp8_per = 8'b1000_1000;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 0);
      check($sformatf("rst k%0d clk_out", k), clk_out, exp8_clk[k]);
      check($sformatf("rst k%0d period_tick", k), period_tick, exp8_per[k]);
      check($sformatf("rst k%0d cfg_ready", k), cfg_ready, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
